// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared types and defaults for the alarm-clock alarm sequencer
package aclk_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } aclk_alm_state_t;

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } aclk_bcd_time_t;

    localparam int ACLK_SNOOZE_MIN       = 5;
    localparam int ACLK_RING_TIMEOUT_SEC = 60;
    localparam int ACLK_MAX_SNOOZES      = 3;

endpackage

// File: rtl/aclk_tick_counter.sv
// rtl/aclk_tick_counter.sv - loadable up/down tick counter with terminal-count flag
module aclk_tick_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    input  logic             count_up,
    input  logic [WIDTH-1:0] term_value,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    // clear outranks load, load outranks a tick arriving in the same cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick) begin
            count <= count_up ? count + WIDTH'(1) : count - WIDTH'(1);
        end
    end

    assign terminal = (count == term_value);

endmodule

// File: rtl/aclk_alarm_sequencer.sv
// rtl/aclk_alarm_sequencer.sv - alarm due detection and ring/snooze/stop/timeout sequencing
module aclk_alarm_sequencer
    import aclk_pkg::*;
#(
    parameter int SNOOZE_MIN       = ACLK_SNOOZE_MIN,
    parameter int RING_TIMEOUT_SEC = ACLK_RING_TIMEOUT_SEC,
    parameter int MAX_SNOOZES      = ACLK_MAX_SNOOZES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       one_minute,
    input  logic       alarm_enable,
    input  logic       snooze_button,
    input  logic       stop_button,
    input  logic [3:0] cur_ms_hr,
    input  logic [3:0] cur_ls_hr,
    input  logic [3:0] cur_ms_min,
    input  logic [3:0] cur_ls_min,
    input  logic [3:0] alm_ms_hr,
    input  logic [3:0] alm_ls_hr,
    input  logic [3:0] alm_ms_min,
    input  logic [3:0] alm_ls_min,
    output logic       alarm_sound,
    output logic       snooze_active,
    output logic [2:0] snoozes_left
);

    aclk_bcd_time_t  cur_time;
    aclk_bcd_time_t  alm_time;
    aclk_alm_state_t state;

    logic match, match_q, due;
    logic snooze_ok;
    logic sec_clear, sec_tick, sec_term;
    logic min_clear, min_load, min_tick, min_term;

    assign cur_time = {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min};
    assign alm_time = {alm_ms_hr, alm_ls_hr, alm_ms_min, alm_ls_min};
    assign match    = (cur_time == alm_time);
    assign due      = match & ~match_q;

    // Counters idle at zero outside their own state, so entry always starts fresh
    always_comb begin
        snooze_ok = snooze_button && (snoozes_left != 3'd0);
        sec_tick  = (state == ST_RINGING) && one_second;
        sec_clear = !alarm_enable || (state != ST_RINGING);
        min_load  = alarm_enable && (state == ST_RINGING) && !stop_button && snooze_ok;
        min_tick  = (state == ST_SNOOZE) && one_minute;
        min_clear = !alarm_enable || ((state != ST_SNOOZE) && !min_load);
    end

    aclk_tick_counter #(.WIDTH(8)) u_sec_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (sec_clear),
        .load       (1'b0),
        .load_value (8'd0),
        .tick       (sec_tick),
        .count_up   (1'b1),
        .term_value (8'(RING_TIMEOUT_SEC - 1)),
        .terminal   (sec_term)
    );

    aclk_tick_counter #(.WIDTH(4)) u_min_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (min_clear),
        .load       (min_load),
        .load_value (4'(SNOOZE_MIN)),
        .tick       (min_tick),
        .count_up   (1'b0),
        .term_value (4'd1),
        .terminal   (min_term)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_DISARMED;
            match_q       <= 1'b0;
            alarm_sound   <= 1'b0;
            snooze_active <= 1'b0;
            snoozes_left  <= 3'd0;
        end else begin
            match_q <= match;
            if (!alarm_enable) begin
                state         <= ST_DISARMED;
                alarm_sound   <= 1'b0;
                snooze_active <= 1'b0;
                snoozes_left  <= 3'd0;
            end else begin
                case (state)
                    ST_DISARMED: begin
                        state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (due) begin
                            state        <= ST_RINGING;
                            alarm_sound  <= 1'b1;
                            snoozes_left <= 3'(MAX_SNOOZES);
                        end
                    end
                    ST_RINGING: begin
                        if (stop_button) begin
                            state       <= ST_ARMED;
                            alarm_sound <= 1'b0;
                        end else if (snooze_ok) begin
                            state         <= ST_SNOOZE;
                            alarm_sound   <= 1'b0;
                            snooze_active <= 1'b1;
                            snoozes_left  <= snoozes_left - 3'd1;
                        end else if (sec_tick && sec_term) begin
                            state       <= ST_ARMED;
                            alarm_sound <= 1'b0;
                        end
                    end
                    ST_SNOOZE: begin
                        if (stop_button) begin
                            state         <= ST_ARMED;
                            snooze_active <= 1'b0;
                        end else if (min_tick && min_term) begin
                            state         <= ST_RINGING;
                            alarm_sound   <= 1'b1;
                            snooze_active <= 1'b0;
                        end
                    end
                    default: begin
                        state         <= ST_DISARMED;
                        alarm_sound   <= 1'b0;
                        snooze_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aclk_alarm_sequencer.sv
// tb/tb_aclk_alarm_sequencer.sv - self-checking bench for the alarm sequencer
module tb_aclk_alarm_sequencer;

    localparam int SNZ_MIN = 5;
    localparam int TIMEOUT = 60;
    localparam int MAX_SNZ = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic       one_minute = 1'b0;
    logic       alarm_enable = 1'b0;
    logic       snooze_button = 1'b0;
    logic       stop_button = 1'b0;
    logic [3:0] cur_ms_hr = 4'd0, cur_ls_hr = 4'd7, cur_ms_min = 4'd2, cur_ls_min = 4'd9;
    logic [3:0] alm_ms_hr = 4'd0, alm_ls_hr = 4'd7, alm_ms_min = 4'd3, alm_ls_min = 4'd0;
    logic       alarm_sound;
    logic       snooze_active;
    logic [2:0] snoozes_left;

    int n_checks = 0;
    int n_fail   = 0;

    aclk_alarm_sequencer #(
        .SNOOZE_MIN       (SNZ_MIN),
        .RING_TIMEOUT_SEC (TIMEOUT),
        .MAX_SNOOZES      (MAX_SNZ)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .one_minute    (one_minute),
        .alarm_enable  (alarm_enable),
        .snooze_button (snooze_button),
        .stop_button   (stop_button),
        .cur_ms_hr     (cur_ms_hr),
        .cur_ls_hr     (cur_ls_hr),
        .cur_ms_min    (cur_ms_min),
        .cur_ls_min    (cur_ls_min),
        .alm_ms_hr     (alm_ms_hr),
        .alm_ls_hr     (alm_ls_hr),
        .alm_ms_min    (alm_ms_min),
        .alm_ls_min    (alm_ls_min),
        .alarm_sound   (alarm_sound),
        .snooze_active (snooze_active),
        .snoozes_left  (snoozes_left)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0=off, 1=armed, 2=ringing, 3=snoozing
    int m_mode = 0;
    int m_secs = 0;
    int m_mins = 0;
    int m_left = 0;
    bit m_prev_eq = 1'b0;
    bit m_eq;
    bit m_rise;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_secs = 0; m_mins = 0; m_left = 0; m_prev_eq = 1'b0;
        end else begin
            m_eq = ({cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} ==
                    {alm_ms_hr, alm_ls_hr, alm_ms_min, alm_ls_min});
            m_rise = m_eq && !m_prev_eq;
            m_prev_eq = m_eq;
            if (!alarm_enable) begin
                m_mode = 0; m_secs = 0; m_mins = 0; m_left = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_rise) begin m_mode = 2; m_left = MAX_SNZ; m_secs = 0; end
            end else if (m_mode == 2) begin
                if (stop_button) m_mode = 1;
                else if (snooze_button && m_left > 0) begin
                    m_mode = 3; m_left = m_left - 1; m_mins = SNZ_MIN;
                end else if (one_second) begin
                    m_secs = m_secs + 1;
                    if (m_secs >= TIMEOUT) m_mode = 1;
                end
            end else begin
                if (stop_button) m_mode = 1;
                else if (one_minute) begin
                    m_mins = m_mins - 1;
                    if (m_mins == 0) begin m_mode = 2; m_secs = 0; end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("model_sound", int'(alarm_sound), int'(m_mode == 2));
        check("model_snooze", int'(snooze_active), int'(m_mode == 3));
        check("model_left", int'(snoozes_left), m_left);
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_cur(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        cur_ms_hr = a; cur_ls_hr = b; cur_ms_min = c; cur_ls_min = d;
    endtask

    task automatic ring_up();
        set_cur(4'd0, 4'd7, 4'd2, 4'd9);
        tick();
        set_cur(4'd0, 4'd7, 4'd3, 4'd0);
        tick();
    endtask

    task automatic press_snooze();
        snooze_button = 1'b1; tick(); snooze_button = 1'b0;
    endtask

    task automatic minute_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            one_minute = 1'b1; tick(); one_minute = 1'b0; tick();
        end
    endtask

    initial begin
        tick(); tick();
        check("reset_sound", int'(alarm_sound), 0);
        check("reset_snooze", int'(snooze_active), 0);
        check("reset_left", int'(snoozes_left), 0);

        reset = 1'b1; alarm_enable = 1'b1;
        tick(); tick();
        set_cur(4'd0, 4'd7, 4'd3, 4'd0);
        tick();
        check("due_sound", int'(alarm_sound), 1);
        check("due_left", int'(snoozes_left), 3);
        stop_button = 1'b1; tick(); stop_button = 1'b0;
        check("stop_sound", int'(alarm_sound), 0);
        repeat (5) tick();
        check("no_rering", int'(alarm_sound), 0);

        ring_up();
        check("ring2_sound", int'(alarm_sound), 1);
        for (int s = 0; s < 3; s++) begin
            press_snooze();
            check("snz_active", int'(snooze_active), 1);
            check("snz_left", int'(snoozes_left), 2 - s);
            minute_ticks(SNZ_MIN - 1);
            check("snz_still", int'(snooze_active), 1);
            minute_ticks(1);
            check("snz_expire", int'(alarm_sound), 1);
        end
        press_snooze();
        check("snz4_sound", int'(alarm_sound), 1);
        check("snz4_left", int'(snoozes_left), 0);

        for (int i = 0; i < TIMEOUT - 1; i++) begin
            one_second = 1'b1; tick(); one_second = 1'b0; tick();
        end
        check("t59_sound", int'(alarm_sound), 1);
        one_second = 1'b1; tick(); one_second = 1'b0;
        check("t60_sound", int'(alarm_sound), 0);

        ring_up();
        stop_button = 1'b1; snooze_button = 1'b1; tick();
        stop_button = 1'b0; snooze_button = 1'b0;
        check("both_sound", int'(alarm_sound), 0);
        check("both_snooze", int'(snooze_active), 0);
        check("both_left", int'(snoozes_left), 3);

        ring_up();
        press_snooze();
        check("pre_dis_snooze", int'(snooze_active), 1);
        alarm_enable = 1'b0; tick();
        check("dis_snooze", int'(snooze_active), 0);
        check("dis_left", int'(snoozes_left), 0);
        alarm_enable = 1'b1;
        repeat (4) tick();
        check("reen_no_ring", int'(alarm_sound), 0);

        ring_up();
        check("ring4_sound", int'(alarm_sound), 1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_sound", int'(alarm_sound), 0);
        check("async_rst_left", int'(snoozes_left), 0);
        set_cur(4'd0, 4'd0, 4'd0, 4'd0);
        alm_ms_hr = 4'd0; alm_ls_hr = 4'd0; alm_ms_min = 4'd0; alm_ls_min = 4'd0;
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("zero_no_ring", int'(alarm_sound), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aclk_alarm_sequencer.md
# aclk_alarm_sequencer

Alarm-event controller for the alarm clock. Watches the current-time and alarm-time BCD digits, detects the minute the alarm becomes due, and sequences the alarm sounder through ring, snooze, stop and auto-timeout. Sits between the time counter / alarm register outputs and the display stage, and replaces a bare equality compare as the sole source of `alarm_sound`.

## Interface
- `SNOOZE_MIN`, default 5: snooze length in `one_minute` ticks, range 1..15.
- `RING_TIMEOUT_SEC`, default 60: `one_second` ticks of unanswered ringing before auto-stop, range 1..255.
- `MAX_SNOOZES`, default 3: snoozes allowed per alarm event, range 0..7.
- `clock` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `one_second` in 1: single-cycle tick from the timing generator.
- `one_minute` in 1: single-cycle tick from the timing generator.
- `alarm_enable` in 1: level; 0 disarms the alarm.
- `snooze_button` in 1: single-cycle pulse (already debounced).
- `stop_button` in 1: single-cycle pulse (already debounced).
- `cur_ms_hr`, `cur_ls_hr`, `cur_ms_min`, `cur_ls_min` in 4 each: current time, BCD.
- `alm_ms_hr`, `alm_ls_hr`, `alm_ms_min`, `alm_ls_min` in 4 each: alarm time, BCD.
- `alarm_sound` out 1: registered, high while ringing.
- `snooze_active` out 1: registered, high while snoozing.
- `snoozes_left` out 3: remaining snoozes for the current event.

## Operation
- States: DISARMED, ARMED, RINGING, SNOOZE.
- `match` = all four digit pairs equal. `match_q` is `match` registered every cycle in every state. `due` = `match & ~match_q`, which is a rising edge of equality.
- DISARMED -> ARMED when `alarm_enable`=1. `due` is not evaluated in DISARMED.
- ARMED -> RINGING on `due`. Entry sets `snoozes_left`=`MAX_SNOOZES` and clears the second counter.
- RINGING:
  - The second counter increments on `one_second`.
  - `stop_button` -> ARMED.
  - `snooze_button` with `snoozes_left`>0 -> SNOOZE. This decrements `snoozes_left` and loads the minute counter with `SNOOZE_MIN`.
  - `snooze_button` with `snoozes_left`=0 is ignored.
  - Counter reaching `RING_TIMEOUT_SEC` -> ARMED.
- SNOOZE:
  - The minute counter decrements on `one_minute`.
  - When it reaches 0 -> RINGING, with the second counter cleared and `snoozes_left` kept.
  - `stop_button` -> ARMED.
  - `due` is ignored.
- `alarm_enable`=0 in any state -> DISARMED next edge and clears all counters.
- Priority within one cycle, highest first: disable > stop > snooze > ring timeout / snooze expiry.
- Since `due` is an edge, a stopped alarm does not re-ring within the same minute. Enabling while times already match does not ring.
- Changing the alarm time during SNOOZE does not cancel the snooze.

## Timing
- Reset values: state DISARMED; `alarm_sound`=0, `snooze_active`=0, `snoozes_left`=0; all counters 0; `match_q`=0.
- `alarm_sound` rises on the same edge that samples `due`=1 in ARMED, so the latency from the time change to sound is one clock.
- `alarm_sound` and `snooze_active` are decoded from next-state into flops. They are never high together and change on the same edge as the state.
- A button press takes effect on the edge that samples it.
- A tick coinciding with a button uses the priority order above.
- Snooze expiry: the edge sampling the `SNOOZE_MIN`-th `one_minute` tick enters RINGING.
- Timeout: the edge sampling the `RING_TIMEOUT_SEC`-th `one_second` tick in RINGING enters ARMED.
- Reset asserted mid-ring or mid-snooze: outputs drop asynchronously to their reset values.
- After reset release with `alarm_enable`=1, the first edge goes to ARMED. `match_q` is then valid, so equal times at reset (00:00 vs 00:00) do not ring.

## Structure
- Shared package `aclk_pkg`:
  - state enum `aclk_alm_state_t`;
  - BCD time struct of four 4-bit digits;
  - default parameter constants.
- One sub-module, `aclk_tick_counter`: a loadable up/down counter with tick enable, a terminal-count flag and synchronous clear. It is instantiated twice, once for seconds (8 bits) and once for minutes (4 bits).
- The comparator and FSM live in the top of this block.

## Test plan
- Alarm 07:30, current steps 07:29 -> 07:30 with enable=1 -> `alarm_sound`=1 one clock later and `snoozes_left`=3. `stop_button` -> `alarm_sound`=0 next edge. No re-ring while current stays 07:30.
- Ringing, snooze pressed -> `snooze_active`=1, `snoozes_left`=2. After 5 `one_minute` ticks -> `alarm_sound`=1. Repeat three snoozes; a fourth press leaves `alarm_sound`=1 and `snoozes_left`=0.
- Ringing with no buttons for 60 `one_second` ticks -> ARMED and `alarm_sound`=0 on the 60th tick edge. At 59 ticks it is still 1.
- `stop_button` and `snooze_button` in the same cycle while ringing -> ARMED, `snooze_active`=0, `snoozes_left` unchanged.
- `alarm_enable` dropped during SNOOZE -> DISARMED next edge with all outputs 0. Re-enable while times match -> no ring.
- `reset` asserted low mid-ring between clock edges -> `alarm_sound`=0 immediately. Release with enable=1 and both times 00:00 -> no ring.
